bip_control: RTL

BIP_CONTROL -- requirements
Module: bip_control

---
 rtl/bip_pkg.sv | 39 +++
 rtl/bip_decoder.sv | 47 ++++
 rtl/bip_control.sv | 82 ++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared constants for the BIP controller: widths, opcodes, FSM encoding and
// the decoded control bundle.
package bip_pkg;

  localparam int BIP_PC_LENGTH          = 11;
  localparam int BIP_OPCODE_LENGTH      = 5;
  localparam int BIP_OPERAND_LENGTH     = 11;
  localparam int BIP_INSTRUCTION_LENGTH = BIP_OPCODE_LENGTH + BIP_OPERAND_LENGTH;

  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_STO  = 5'b00001;
  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_LD   = 5'b00010;
  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [BIP_OPCODE_LENGTH-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM     = 2'b00;
  localparam logic [1:0] SELA_OPERAND = 2'b01;
  localparam logic [1:0] SELA_ALU     = 2'b10;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } stateT;

  typedef struct packed {
    logic [1:0] selA;
    logic       selB;
    logic       op;
    logic       wrAcc;
    logic       wrRam;
    logic       rdRam;
  } ctrlT;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode-to-control decode; everything is forced low unless the
// controller is in EXECUTE.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPCODE_LENGTH = BIP_OPCODE_LENGTH
) (
  input  logic                     inExecute,
  input  logic [OPCODE_LENGTH-1:0] inOpcode,
  output ctrlT                     outCtrl,
  output logic                     outIsHlt
);

  always_comb begin
    outCtrl  = '0;
    outIsHlt = (inOpcode == OP_HLT);
    if (inExecute) begin
      case (inOpcode)
        OP_STO: outCtrl.wrRam = 1'b1;
        OP_LD: begin
          outCtrl.selA  = SELA_RAM;
          outCtrl.wrAcc = 1'b1;
          outCtrl.rdRam = 1'b1;
        end
        OP_LDI: begin
          outCtrl.selA  = SELA_OPERAND;
          outCtrl.wrAcc = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          outCtrl.selA  = SELA_ALU;
          outCtrl.op    = (inOpcode == OP_SUB);
          outCtrl.wrAcc = 1'b1;
          outCtrl.rdRam = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          outCtrl.selA  = SELA_ALU;
          outCtrl.selB  = 1'b1;
          outCtrl.op    = (inOpcode == OP_SUBI);
          outCtrl.wrAcc = 1'b1;
        end
        // HLT and the unused opcode space decode to no strobes
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: PC, instruction register and the fetch/decode/execute FSM.
//   state   | meaning
//   FETCH   | PC on the bus; wait for inEnable
//   DECODE  | instruction register captures inInstruction
//   EXECUTE | strobes driven from the opcode; PC advances unless HLT
//   HALT    | terminal until reset
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_LENGTH          = BIP_PC_LENGTH,
  parameter int OPCODE_LENGTH      = BIP_OPCODE_LENGTH,
  parameter int OPERAND_LENGTH     = BIP_OPERAND_LENGTH,
  parameter int INSTRUCTION_LENGTH = OPCODE_LENGTH + OPERAND_LENGTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inEnable,
  input  logic [INSTRUCTION_LENGTH-1:0] inInstruction,
  output logic [PC_LENGTH-1:0]          outPcAddr,
  output logic [OPERAND_LENGTH-1:0]     outOperand,
  output logic [1:0]                    outSelA,
  output logic                          outSelB,
  output logic                          outOp,
  output logic                          outWrAcc,
  output logic                          outWrRam,
  output logic                          outRdRam,
  output logic                          outHalted
);

  stateT                         state;
  stateT                         nextState;
  logic [PC_LENGTH-1:0]          pcReg;
  logic [INSTRUCTION_LENGTH-1:0] irReg;
  ctrlT                          ctrl;
  logic                          isHlt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pcReg <= '0;
      irReg <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE)
        irReg <= inInstruction;
      // PC width sets the natural wrap from all-ones back to zero
      if (state == EXECUTE && !isHlt)
        pcReg <= pcReg + PC_LENGTH'(1);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:   if (inEnable) nextState = DECODE;
      DECODE:  nextState = EXECUTE;
      EXECUTE: nextState = isHlt ? HALT : FETCH;
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  bip_decoder #(
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) uDecoder (
    .inExecute (state == EXECUTE),
    .inOpcode  (irReg[INSTRUCTION_LENGTH-1 -: OPCODE_LENGTH]),
    .outCtrl   (ctrl),
    .outIsHlt  (isHlt)
  );

  assign outPcAddr  = pcReg;
  assign outOperand = irReg[OPERAND_LENGTH-1:0];
  assign outSelA    = ctrl.selA;
  assign outSelB    = ctrl.selB;
  assign outOp      = ctrl.op;
  assign outWrAcc   = ctrl.wrAcc;
  assign outWrRam   = ctrl.wrRam;
  assign outRdRam   = ctrl.rdRam;
  assign outHalted  = (state == HALT);

endmodule
